// File: rtl/hdmi_src_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI pixel-source arbiter:
//   - state_t     : start-up / run states of the top-level sequencer
//   - pw()        : pixel width from bits per colour channel ({R,G,B})
//   - BLACK_PIXEL : all-zero pixel, sliced down to the pixel width in use
//   - sat_inc8()  : 8-bit saturating increment used by the dwell counter
// ---------------------------------------------------------------------------
package hdmi_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Widest pixel supported (16 bits per colour).
    localparam int MAX_PW = 48;

    localparam logic [MAX_PW-1:0] BLACK_PIXEL = '0;

    function automatic int pw(input int bits_per_color);
        return 3 * bits_per_color;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hdmi_src_arbiter_if.sv
// ---------------------------------------------------------------------------
// hdmi_arb_if
// Bundles the encoder request stream, the two source pixel buses and the
// arbiter outputs. Names are given from the arbiter's point of view:
// i_* are driven towards the arbiter, o_* are driven by it.
//   slave  : arbiter side (takes i_*, drives o_*)
//   master : encoder/sources side (drives i_*, takes o_*)
// ---------------------------------------------------------------------------
interface hdmi_arb_if
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_COLOR = 8
);
    localparam int PW = pw(BITS_PER_COLOR);

    logic          i_rd;
    logic          i_newline;
    logic          i_newframe;
    logic [1:0]    i_req;
    logic [PW-1:0] i_pixel0;
    logic [PW-1:0] i_pixel1;

    logic          o_sink_reset;
    logic [1:0]    o_rd;
    logic          o_newline;
    logic          o_newframe;
    logic [PW-1:0] o_pixel;
    logic [1:0]    o_grant;
    logic          o_running;

    modport slave (
        input  i_rd, i_newline, i_newframe, i_req, i_pixel0, i_pixel1,
        output o_sink_reset, o_rd, o_newline, o_newframe, o_pixel,
               o_grant, o_running
    );

    modport master (
        output i_rd, i_newline, i_newframe, i_req, i_pixel0, i_pixel1,
        input  o_sink_reset, o_rd, o_newline, o_newframe, o_pixel,
               o_grant, o_running
    );

endinterface

// File: rtl/hdmi_src_arbiter_frame_rr_arb.sv
// ---------------------------------------------------------------------------
// frame_rr_arb
// Two-way round-robin grant decision with a dwell counter. The decision is
// taken only when i_en is high (one cycle per frame strobe); otherwise the
// grant and dwell hold, so request changes inside a frame are invisible.
// Ports:
//   i_clk      clock
//   i_reset_n  synchronous active-low reset (grant=0, dwell=0)
//   i_en       evaluate arbitration this cycle
//   i_req      per-source request levels
//   o_grant    registered one-hot-or-zero owner
// ---------------------------------------------------------------------------
module frame_rr_arb
    import hdmi_pkg::*;
#(
    parameter int DWELL_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    localparam logic [7:0] DWELL_LIMIT = 8'(DWELL_FRAMES - 1);

    logic [1:0] r_grant;
    logic [7:0] r_dwell;
    logic [1:0] w_grant_nxt;
    logic [7:0] w_dwell_nxt;
    logic       w_cur;
    logic       w_cur_req;
    logic       w_oth_req;

    always_comb begin
        w_grant_nxt = r_grant;
        w_dwell_nxt = r_dwell;
        // With a one-hot grant, bit 1 of the grant is the owner index.
        w_cur       = r_grant[1];
        w_cur_req   = i_req[w_cur];
        w_oth_req   = i_req[~w_cur];

        if (i_en) begin
            if (r_grant == 2'b00) begin
                // Nobody owns the stream: source 0 has priority.
                w_dwell_nxt = '0;
                if (i_req[0]) begin
                    w_grant_nxt = 2'b01;
                end else if (i_req[1]) begin
                    w_grant_nxt = 2'b10;
                end else begin
                    w_grant_nxt = 2'b00;
                end
            end else if (w_cur_req && (!w_oth_req || (r_dwell < DWELL_LIMIT))) begin
                // Owner keeps the stream; dwell only matters when contested.
                w_dwell_nxt = sat_inc8(r_dwell);
            end else if (w_oth_req) begin
                w_grant_nxt = {r_grant[0], r_grant[1]};
                w_dwell_nxt = '0;
            end else begin
                w_grant_nxt = 2'b00;
                w_dwell_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_grant <= 2'b00;
            r_dwell <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/hdmi_src_arbiter.sv
// ---------------------------------------------------------------------------
// hdmi_src_arbiter
// Shares the HDMI encoder's pixel-request stream between two pixel sources,
// switching ownership only at frame strobes. Also sequences start-up: holds
// the encoder and sources in reset for RESET_TICKS cycles, then waits for the
// first frame strobe before serving any source.
// Ports:
//   i_pixclk   pixel clock, all logic on its rising edge
//   i_reset_n  synchronous active-low reset
//   bus        hdmi_arb_if.slave:
//                i_rd/i_newline/i_newframe  encoder request stream
//                i_req                      per-source request levels
//                i_pixel0/i_pixel1          source pixels {R,G,B}
//                o_sink_reset               reset to encoder and sources
//                o_rd                       i_rd gated per source
//                o_newline/o_newframe       strobes passed to both sources
//                o_pixel                    granted source pixel, or black
//                o_grant                    current owner (one-hot or zero)
//                o_running                  high once aligned to a frame
// ---------------------------------------------------------------------------
module hdmi_src_arbiter
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_COLOR = 8,
    parameter int RESET_TICKS    = 8,
    parameter int DWELL_FRAMES   = 60
) (
    input  logic       i_pixclk,
    input  logic       i_reset_n,
    hdmi_arb_if.slave  bus
);

    localparam int         PW        = pw(BITS_PER_COLOR);
    localparam logic [7:0] TICK_LAST = 8'(RESET_TICKS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_tick;
    logic [7:0] w_tick_nxt;
    logic       w_arb_en;
    logic [1:0] w_grant;
    logic       w_live;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        case (r_state)
            HOLD: begin
                if (r_tick == TICK_LAST) begin
                    w_state_nxt = SYNC;
                end else begin
                    w_tick_nxt = r_tick + 8'd1;
                end
            end
            SYNC: begin
                if (bus.i_newframe) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = HOLD;
                w_tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            r_state <= HOLD;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Frame strobes during HOLD are ignored; the SYNC strobe both starts RUN
    // and makes the first grant decision.
    assign w_arb_en = bus.i_newframe && (r_state != HOLD);

    frame_rr_arb #(
        .DWELL_FRAMES (DWELL_FRAMES)
    ) u_arb (
        .i_clk     (i_pixclk),
        .i_reset_n (i_reset_n),
        .i_en      (w_arb_en),
        .i_req     (bus.i_req),
        .o_grant   (w_grant)
    );

    // i_reset_n is folded in so the outputs blank in the very cycle reset is
    // asserted, before the registers clear at the next edge.
    assign w_live = (r_state == RUN) && i_reset_n;

    assign bus.o_sink_reset = (r_state == HOLD);
    assign bus.o_running    = (r_state == RUN);
    assign bus.o_grant      = w_grant;
    assign bus.o_newline    = bus.i_newline;
    assign bus.o_newframe   = bus.i_newframe;
    assign bus.o_rd         = {2{bus.i_rd & w_live}} & w_grant;

    // Zero-latency mux: keeps the encoder's rd-to-pixel timing untouched.
    always_comb begin
        bus.o_pixel = BLACK_PIXEL[PW-1:0];
        if (w_live) begin
            if (w_grant[0]) begin
                bus.o_pixel = bus.i_pixel0;
            end else if (w_grant[1]) begin
                bus.o_pixel = bus.i_pixel1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_src_arbiter.sv
module tb_hdmi_src_arbiter;
    import hdmi_pkg::*;

    localparam int BPC   = 8;
    localparam int PWT   = 3 * BPC;
    localparam int TICKS = 8;
    localparam int DWELL = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] exp_q[$];
    logic [1:0] cur_grant;
    int         m_owner;
    int         m_dwell;

    hdmi_arb_if #(.BITS_PER_COLOR(BPC)) bus ();

    hdmi_src_arbiter #(
        .BITS_PER_COLOR (BPC),
        .RESET_TICKS    (TICKS),
        .DWELL_FRAMES   (DWELL)
    ) dut (
        .i_pixclk  (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration at a frame strobe.
    function automatic logic [1:0] model_frame(input logic [1:0] req);
        int oth;
        if (m_owner < 0) begin
            m_dwell = 0;
            if (req[0])      m_owner = 0;
            else if (req[1]) m_owner = 1;
        end else begin
            oth = 1 - m_owner;
            if (req[m_owner] && (!req[oth] || m_dwell < DWELL - 1)) begin
                m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
            end else if (req[oth]) begin
                m_owner = oth;
                m_dwell = 0;
            end else begin
                m_owner = -1;
                m_dwell = 0;
            end
        end
        return (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic run_frame(input logic [1:0] req, input logic [1:0] req_mid,
                             input int n_rd, output logic [1:0] got);
        logic [1:0]     expg;
        logic [PWT-1:0] p0, p1, pexp;
        @(negedge clk);
        bus.i_req      = req;
        bus.i_newframe = 1'b1;
        exp_q.push_back(model_frame(req));
        #1;
        chk("grant_at_strobe", 32'(bus.o_grant), 32'(cur_grant));
        chk("newframe_pass", 32'(bus.o_newframe), 32'd1);
        @(negedge clk);
        bus.i_newframe = 1'b0;
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            expg = 2'b00;
        end else begin
            expg = exp_q.pop_front();
        end
        chk("grant", 32'(bus.o_grant), 32'(expg));
        chk("running", 32'(bus.o_running), 32'd1);
        got       = bus.o_grant;
        cur_grant = expg;
        for (int i = 0; i < n_rd; i++) begin
            @(negedge clk);
            p0 = PWT'($urandom);
            p1 = PWT'($urandom);
            bus.i_rd     = 1'b1;
            bus.i_pixel0 = p0;
            bus.i_pixel1 = p1;
            if (i == n_rd / 2) bus.i_req = req_mid;
            pexp = expg[0] ? p0 : (expg[1] ? p1 : '0);
            #1;
            chk("o_rd", 32'(bus.o_rd), 32'(expg));
            chk("o_pixel", 32'(bus.o_pixel), 32'(pexp));
        end
        @(negedge clk);
        bus.i_rd = 1'b0;
        #1;
        chk("grant_frame_end", 32'(bus.o_grant), 32'(expg));
        repeat (2) @(negedge clk);
    endtask

    logic [1:0] rr_exp [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};

    initial begin
        int         cnt;
        logic [1:0] g;
        reset_n        = 1'b0;
        bus.i_rd       = 1'b0;
        bus.i_newline  = 1'b0;
        bus.i_newframe = 1'b0;
        bus.i_req      = 2'b00;
        bus.i_pixel0   = 24'h123456;
        bus.i_pixel1   = 24'h654321;
        m_owner        = -1;
        m_dwell        = 0;
        cur_grant      = 2'b00;

        repeat (3) @(negedge clk);
        bus.i_rd = 1'b1;
        #1;
        chk("rst_sink_reset", 32'(bus.o_sink_reset), 32'd1);
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_running", 32'(bus.o_running), 32'd0);
        chk("rst_rd", 32'(bus.o_rd), 32'd0);
        chk("rst_pixel", 32'(bus.o_pixel), 32'd0);
        bus.i_rd = 1'b0;

        // Start-up: count cycles o_sink_reset stays high once reset releases.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        cnt = 0;
        while (bus.o_sink_reset && cnt < 300) begin
            cnt++;
            bus.i_newframe = (cnt == 3);
            bus.i_req      = 2'b01;
            @(negedge clk);
            #1;
        end
        bus.i_newframe = 1'b0;
        chk("hold_ticks", 32'(cnt), 32'(TICKS));
        chk("sync_running", 32'(bus.o_running), 32'd0);
        chk("sync_grant", 32'(bus.o_grant), 32'd0);
        bus.i_rd = 1'b1;
        #1;
        chk("sync_rd", 32'(bus.o_rd), 32'd0);
        chk("sync_pixel", 32'(bus.o_pixel), 32'd0);
        bus.i_rd = 1'b0;

        // Single requester over three frames.
        repeat (3) run_frame(2'b01, 2'b01, 4, g);
        // Source 0 drops its request mid-frame; it keeps this frame.
        run_frame(2'b01, 2'b10, 4, g);
        run_frame(2'b10, 2'b10, 4, g);
        chk("mid_change_grant", 32'(g), 32'h2);
        // Idle.
        run_frame(2'b00, 2'b00, 3, g);
        chk("idle_grant", 32'(g), 32'h0);
        // Contended: dwell-driven alternation from a zero grant.
        for (int f = 0; f < 6; f++) begin
            run_frame(2'b11, 2'b11, 3, g);
            chk("rr_seq", 32'(g), 32'(rr_exp[f]));
        end

        // Reset for one cycle in the middle of a frame.
        @(negedge clk);
        bus.i_rd     = 1'b1;
        bus.i_pixel0 = 24'hABCDEF;
        reset_n      = 1'b0;
        #1;
        chk("rstmid_pixel_now", 32'(bus.o_pixel), 32'd0);
        chk("rstmid_rd_now", 32'(bus.o_rd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rstmid_sink_reset", 32'(bus.o_sink_reset), 32'd1);
        chk("rstmid_grant", 32'(bus.o_grant), 32'd0);
        chk("rstmid_running", 32'(bus.o_running), 32'd0);
        chk("rstmid_pixel", 32'(bus.o_pixel), 32'd0);
        chk("rstmid_rd", 32'(bus.o_rd), 32'd0);
        bus.i_rd = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
